// File: rtl/raster_pkg.sv
// raster_pkg: shared definitions for the multi-pixel raster stream blocks.
//   tx_state_t   - transmit FSM state encoding
//   row_width()  - row counter width for a given max row count
//   beat_width() - beat counter width for given max columns / pixels per beat
//   RASTER_*     - default geometry, reusable by the filter blocks
package raster_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_VBLANK,
    ST_LINE,
    ST_HBLANK,
    ST_DONE
  } tx_state_t;

  function automatic int unsigned row_width(input int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic int unsigned beat_width(input int unsigned cols, input int unsigned pixcnt);
    return (cols / pixcnt > 1) ? $clog2(cols / pixcnt) : 1;
  endfunction

  localparam int unsigned RASTER_ROWS   = 2049;
  localparam int unsigned RASTER_COLS   = 2448;
  localparam int unsigned RASTER_PIXCNT = 8;
  localparam int unsigned RASTER_ROW_W  = row_width(RASTER_ROWS);
  localparam int unsigned RASTER_BEAT_W = beat_width(RASTER_COLS, RASTER_PIXCNT);

endpackage

// File: rtl/raster_stream_tx_blank_timer.sv
// blank_timer: loadable down-counter used for vertical and horizontal blanking.
//   clk, rst  - clock, synchronous active-high reset
//   load      - load load_val (takes priority over en)
//   load_val  - cycles-minus-one to spend in the blank state
//   en        - decrement while nonzero
//   done      - count has reached zero (last blank cycle)
module blank_timer #(
  parameter int unsigned BLANKW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BLANKW-1:0] load_val,
  input  logic              en,
  output logic              done
);

  logic [BLANKW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/raster_stream_tx.sv
// raster_stream_tx: transmit end of the multi-pixel raster stream.
// Emits new_frame, vblank idle cycles, then rows x beats data beats with
// hblank idle cycles between rows, pulling words from a valid/ready source.
//   clk, rst          - clock, synchronous active-high reset
//   start, abort      - begin frame (IDLE only) / terminate frame
//   rows, cols        - frame geometry, latched on accepted start
//   hblank, vblank    - blanking cycle counts, latched on accepted start
//   s_data/valid/ready- upstream pixel words (pixel 0 in LSBs)
//   new_frame         - start-of-frame pulse
//   data_out/data_vld - stream beats (latency 1 from acceptance)
//   busy, frame_done  - frame in progress / frame complete pulse
//   cfg_err           - start rejected (rows or beats zero)
//   stall_cnt         - saturating count of LINE cycles without s_valid
module raster_stream_tx
  import raster_pkg::*;
#(
  parameter int unsigned DWIDTH = 10,
  parameter int unsigned PIXCNT = 8,
  parameter int unsigned ROWS   = 2049,
  parameter int unsigned COLS   = 2448,
  parameter int unsigned BLANKW = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [$clog2(ROWS)-1:0]    rows,
  input  logic [$clog2(COLS)-1:0]    cols,
  input  logic [BLANKW-1:0]          hblank,
  input  logic [BLANKW-1:0]          vblank,
  input  logic [DWIDTH*PIXCNT-1:0]   s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       new_frame,
  output logic [DWIDTH*PIXCNT-1:0]   data_out,
  output logic                       data_vld,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       cfg_err,
  output logic [15:0]                stall_cnt
);

  localparam int unsigned PIXCNTBITS = $clog2(PIXCNT);
  localparam int unsigned ROWW       = row_width(ROWS);
  localparam int unsigned BEATW      = beat_width(COLS, PIXCNT);

  tx_state_t         state, state_next;
  logic [ROWW-1:0]   rows_q, row_cnt;
  logic [BEATW-1:0]  beats_q, beat_cnt, beats_in;
  logic [BLANKW-1:0] hblank_q, vblank_q, tmr_val;
  logic              accept, row_end, last_row, cfg_ok;
  logic              tmr_load, tmr_en, tmr_done;

  assign beats_in = BEATW'(cols >> PIXCNTBITS);
  assign cfg_ok   = (rows != '0) && (beats_in != '0);
  assign s_ready  = (state == ST_LINE);
  assign accept   = s_ready && s_valid;
  assign row_end  = (beat_cnt == beats_q - 1'b1);
  assign last_row = (row_cnt == rows_q - 1'b1);

  // Timer is loaded with (count - 1) on the cycle before entering a blank
  // state so that it reads zero on the last blank cycle.
  assign tmr_load = (state == ST_SOF) || (accept && row_end);
  assign tmr_val  = (state == ST_SOF) ? vblank_q - 1'b1 : hblank_q - 1'b1;
  assign tmr_en   = (state == ST_VBLANK) || (state == ST_HBLANK);

  blank_timer #(.BLANKW(BLANKW)) u_blank_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (start && !abort && cfg_ok) state_next = ST_SOF;
      ST_SOF:    state_next = (vblank_q != '0) ? ST_VBLANK : ST_LINE;
      ST_VBLANK: if (tmr_done) state_next = ST_LINE;
      ST_LINE: begin
        if (accept && row_end) begin
          if (last_row)            state_next = ST_DONE;
          else if (hblank_q != '0) state_next = ST_HBLANK;
        end
      end
      ST_HBLANK: if (tmr_done) state_next = ST_LINE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) state_next = ST_IDLE;
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      new_frame  <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      data_vld   <= 1'b0;
      data_out   <= '0;
      stall_cnt  <= '0;
      rows_q     <= '0;
      beats_q    <= '0;
      hblank_q   <= '0;
      vblank_q   <= '0;
      row_cnt    <= '0;
      beat_cnt   <= '0;
    end else begin
      state      <= state_next;
      busy       <= (state_next != ST_IDLE);
      new_frame  <= (state_next == ST_SOF);
      frame_done <= (state_next == ST_DONE);
      cfg_err    <= (state == ST_IDLE) && start && !abort && !cfg_ok;
      data_vld   <= accept;
      if (accept) data_out <= s_data;

      if (state == ST_IDLE && state_next == ST_SOF) begin
        rows_q    <= rows;
        beats_q   <= beats_in;
        hblank_q  <= hblank;
        vblank_q  <= vblank;
        row_cnt   <= '0;
        beat_cnt  <= '0;
        stall_cnt <= '0;
      end

      if (state == ST_LINE) begin
        if (!s_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        if (accept) begin
          if (row_end) begin
            beat_cnt <= '0;
            row_cnt  <= row_cnt + 1'b1;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule
